trace_reader: RTL and testbench

- Read side of the 256-entry sample capture buffer that the trigger block fills.
- Once a capture is complete, copies the 256 samples into an internal 256-entry screen-Y table at the start of the next frame.
- Answers per-pixel queries from the VGA draw pipeline (65 MHz, 1024x768) with trace-hit and level-marker flags.
- Sits between the capture buffer and the VGA pixel mux.

---
 rtl/oscilloscope_pkg.sv | 17 +
 rtl/trace_table.sv | 20 ++
 rtl/trace_reader.sv | 105 ++++++++++
 tb/tb_trace_reader.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/oscilloscope_pkg.sv
// Shared types and sample-to-screen conversion for the oscilloscope trace path.
package oscilloscope_pkg;
  localparam int BUF_DEPTH = 256;
  localparam int ADDR_W    = 8;
  localparam int SAMPLE_W  = 12;
  localparam int Y_W       = 10;

  typedef enum logic [2:0] {IDLE, LOCK, READ, DRAIN, DONE} state_t;

  // Larger samples sit higher on screen, so the sample is inverted before scaling.
  function automatic logic [Y_W-1:0] sample_to_y(input logic [SAMPLE_W-1:0] s,
                                                 input int shift, input int y0);
    int inv;
    inv = (2**SAMPLE_W - 1) - int'(s);
    return Y_W'(y0 + (inv >> shift));
  endfunction
endpackage

// File: rtl/trace_table.sv
// Simple dual-port screen-Y table; registered read returns old data on a same-address write.
module trace_table #(
  parameter int DEPTH = 256,
  parameter int AW    = 8,
  parameter int DW    = 10
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);
  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end
endmodule

// File: rtl/trace_reader.sv
// Copies a finished capture into the screen-Y table at frame start and answers per-pixel queries.
module trace_reader
  import oscilloscope_pkg::*;
#(
  parameter int SHIFT  = 3,
  parameter int Y0     = 128,
  parameter int X_LOG2 = 2,
  parameter int X0     = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                capture_done,
  input  logic                frame_start,
  output logic [ADDR_W-1:0]   rd_addr,
  input  logic [SAMPLE_W-1:0] rd_data,
  output logic                buf_lock,
  input  logic [10:0]         level_trigger,
  input  logic [10:0]         x_pos,
  input  logic [10:0]         y_pos,
  output logic                trace_pixel,
  output logic                level_pixel,
  output logic                table_valid
);
  localparam int TRACE_COLS = BUF_DEPTH << X_LOG2;

  state_t state, state_nxt;
  logic   pending;

  logic              tbl_we;
  logic [ADDR_W-1:0] tbl_waddr;
  logic [Y_W-1:0]    tbl_wdata, tbl_rdata, ly;
  logic [ADDR_W-1:0] q_idx;
  logic [11:0]       x_rel;
  logic              q_inrange, inrange_q;
  logic [10:0]       y_d;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    buf_lock  = 1'b0;
    case (state)
      IDLE:  if (frame_start && pending) state_nxt = LOCK;
      LOCK:  begin buf_lock = 1'b1; state_nxt = READ; end
      READ:  begin
        buf_lock = 1'b1;
        if (rd_addr == ADDR_W'(BUF_DEPTH - 1)) state_nxt = DRAIN;
      end
      DRAIN: begin buf_lock = 1'b1; state_nxt = DONE; end
      DONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // A capture_done coinciding with the clear still wins, so no capture is lost.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_addr     <= '0;
      pending     <= 1'b0;
      table_valid <= 1'b0;
    end else begin
      rd_addr <= (state == READ) ? rd_addr + 8'd1 : '0;
      if (capture_done)       pending <= 1'b1;
      else if (state == LOCK) pending <= 1'b0;
      if (state == DRAIN)     table_valid <= 1'b1;
    end
  end

  // Data lags the address by one cycle; in DRAIN rd_addr has wrapped to 0, so rd_addr-1 is 255.
  assign tbl_we    = (state == READ && rd_addr != '0) || (state == DRAIN);
  assign tbl_waddr = rd_addr - 8'd1;
  assign tbl_wdata = sample_to_y(rd_data, SHIFT, Y0);

  // Columns left of X0 wrap to >= 2048 and fail the same bound check.
  assign x_rel     = {1'b0, x_pos} - 12'(X0);
  assign q_inrange = x_rel < 12'(TRACE_COLS);
  assign q_idx     = ADDR_W'(x_rel >> X_LOG2);
  assign ly        = sample_to_y({1'b0, level_trigger}, SHIFT, Y0);

  trace_table #(.DEPTH(BUF_DEPTH), .AW(ADDR_W), .DW(Y_W)) u_table (
    .clk   (clk),
    .we    (tbl_we),
    .waddr (tbl_waddr),
    .wdata (tbl_wdata),
    .raddr (q_idx),
    .rdata (tbl_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      inrange_q   <= 1'b0;
      y_d         <= '0;
      trace_pixel <= 1'b0;
      level_pixel <= 1'b0;
    end else begin
      inrange_q   <= q_inrange;
      y_d         <= y_pos;
      trace_pixel <= table_valid & inrange_q & (y_d == {1'b0, tbl_rdata});
      level_pixel <= inrange_q & (y_d == {1'b0, ly});
    end
  end
endmodule

// File: tb/tb_trace_reader.sv
// Bench for trace_reader: capture-buffer model, refresh timing, vector table and random pixel queries.
module tb_trace_reader;
  logic        clk = 1'b0, rst = 1'b1, capture_done = 1'b0, frame_start = 1'b0;
  logic [7:0]  rd_addr;
  logic [11:0] rd_data = '0;
  logic        buf_lock, trace_pixel, level_pixel, table_valid;
  logic [10:0] level_trigger = '0, x_pos = '0, y_pos = '0;

  int checks = 0, failures = 0;
  int buf_mem[256];
  int model_tbl[256];
  bit model_valid = 0;

  typedef struct { int x; int y; int tp; int lp; } vec_t;
  vec_t vecs[11];

  trace_reader dut (
    .clk(clk), .rst(rst), .capture_done(capture_done), .frame_start(frame_start),
    .rd_addr(rd_addr), .rd_data(rd_data), .buf_lock(buf_lock),
    .level_trigger(level_trigger), .x_pos(x_pos), .y_pos(y_pos),
    .trace_pixel(trace_pixel), .level_pixel(level_pixel), .table_valid(table_valid)
  );

  always #5 clk = ~clk;
  always @(posedge clk) rd_data <= 12'(buf_mem[rd_addr]);

  task automatic check(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  function automatic int exp_trace(int x, int y);
    if (!model_valid || x >= 1024) return 0;
    return (model_tbl[x >> 2] == y) ? 1 : 0;
  endfunction

  function automatic int level_row(int lvl);
    return 128 + ((4095 - lvl) >> 3);
  endfunction

  function automatic int exp_level(int x, int y);
    if (x >= 1024) return 0;
    return (y == level_row(int'(level_trigger))) ? 1 : 0;
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic query(int x, int y, output int tp, output int lp);
    x_pos = 11'(x); y_pos = 11'(y);
    tick(); tick();
    tp = int'(trace_pixel); lp = int'(level_pixel);
  endtask

  task automatic query_model(string tag, int x, int y);
    int tp, lp;
    query(x, y, tp, lp);
    check({tag, " trace"}, tp, exp_trace(x, y));
    check({tag, " level"}, lp, exp_level(x, y));
  endtask

  task automatic random_queries(string tag, int n);
    for (int i = 0; i < n; i++) begin
      int x, y, mode;
      x = (i % 17 == 0) ? 2047 : int'($urandom_range(0, 1100));
      mode = int'($urandom_range(0, 2));
      if (mode == 0)                      y = int'($urandom_range(0, 1023));
      else if (mode == 1 || x >= 1024)    y = level_row(int'(level_trigger));
      else                                y = model_tbl[x >> 2];
      query_model(tag, x, y);
    end
  endtask

  task automatic capture();
    capture_done = 1'b1; tick(); capture_done = 1'b0;
  endtask

  // n counts cycles with buf_lock high; cd_at injects a capture_done at that lock cycle.
  task automatic refresh(int cd_at, output int n, output int addr_ok);
    n = 0; addr_ok = 1;
    frame_start = 1'b1; tick(); frame_start = 1'b0;
    while (buf_lock && n < 400) begin
      if (n >= 1 && n <= 256 && int'(rd_addr) != n - 1) addr_ok = 0;
      capture_done = (n == cd_at);
      n++;
      tick();
    end
    capture_done = 1'b0;
  endtask

  task automatic full_refresh(string tag, int cd_at);
    int n, ok;
    refresh(cd_at, n, ok);
    check({tag, " lock cycles"}, n, 258);
    check({tag, " rd_addr order"}, ok, 1);
    tick();
    check({tag, " table_valid"}, int'(table_valid), 1);
    for (int i = 0; i < 256; i++) model_tbl[i] = 128 + ((4095 - buf_mem[i]) >> 3);
    model_valid = 1;
  endtask

  task automatic expect_no_lock(string tag);
    int seen;
    seen = 0;
    frame_start = 1'b1; tick(); frame_start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (buf_lock) seen = 1;
      tick();
    end
    check({tag, " no lock"}, seen, 0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) buf_mem[i] = 0;
    vecs[0]  = '{0,    639, 1, 0};
    vecs[1]  = '{1023, 129, 1, 0};
    vecs[2]  = '{1024, 129, 0, 0};
    vecs[3]  = '{1020, 129, 1, 0};
    vecs[4]  = '{3,    639, 1, 0};
    vecs[5]  = '{4,    639, 0, 0};
    vecs[6]  = '{4,    637, 1, 0};
    vecs[7]  = '{500,  389, 1, 0};
    vecs[8]  = '{500,  508, 0, 1};
    vecs[9]  = '{1024, 508, 0, 0};
    vecs[10] = '{0,    638, 0, 0};

    tick(); tick(); tick();
    check("reset rd_addr", int'(rd_addr), 0);
    check("reset buf_lock", int'(buf_lock), 0);
    check("reset table_valid", int'(table_valid), 0);
    check("reset trace_pixel", int'(trace_pixel), 0);
    check("reset level_pixel", int'(level_pixel), 0);
    rst = 1'b0;
    tick();

    level_trigger = 11'($urandom_range(0, 2047));
    random_queries("empty", 40);
    check("empty table_valid", int'(table_valid), 0);
    expect_no_lock("idle frame");

    // Full-scale buffer: every entry lands on row Y0.
    for (int i = 0; i < 256; i++) buf_mem[i] = 4095;
    capture();
    full_refresh("fullscale", -1);
    begin
      int tp, lp;
      query(100, 128, tp, lp); check("fullscale hit (100,128)", tp, 1);
      query(100, 129, tp, lp); check("fullscale miss (100,129)", tp, 0);
    end

    // Ramp buffer against the hand-computed vector table.
    for (int i = 0; i < 256; i++) buf_mem[i] = i * 16;
    level_trigger = 11'd1054;
    capture();
    full_refresh("ramp", -1);
    for (int i = 0; i < 11; i++) begin
      int tp, lp;
      query(vecs[i].x, vecs[i].y, tp, lp);
      check($sformatf("vec%0d trace (%0d,%0d)", i, vecs[i].x, vecs[i].y), tp, vecs[i].tp);
      check($sformatf("vec%0d level (%0d,%0d)", i, vecs[i].x, vecs[i].y), lp, vecs[i].lp);
    end
    random_queries("ramp", 40);

    // capture_done during READ must queue exactly one more refresh.
    for (int i = 0; i < 256; i++) buf_mem[i] = int'($urandom_range(0, 4095));
    capture();
    full_refresh("first", 50);
    for (int i = 0; i < 256; i++) buf_mem[i] = int'($urandom_range(0, 4095));
    full_refresh("queued", -1);
    level_trigger = 11'($urandom_range(0, 2047));
    random_queries("queued", 60);

    // Reset at READ cycle 100 aborts the copy and drops everything.
    capture();
    frame_start = 1'b1; tick(); frame_start = 1'b0;
    for (int i = 0; i < 101; i++) tick();
    check("mid-read buf_lock before rst", int'(buf_lock), 1);
    rst = 1'b1; tick();
    check("rst buf_lock", int'(buf_lock), 0);
    check("rst table_valid", int'(table_valid), 0);
    rst = 1'b0; model_valid = 0;
    tick();
    random_queries("after rst", 10);
    expect_no_lock("pending cleared");
    for (int i = 0; i < 256; i++) buf_mem[i] = int'($urandom_range(0, 4095));
    capture();
    full_refresh("after rst", -1);
    random_queries("final", 40);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
